// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
//   Shares one single-port unified memory between the IF stage (fetch) and the
//   MEM stage (load/store). Each access runs as a req/ack handshake. The MEM
//   stage wins arbitration unless fetch has been passed over STARVE_LIMIT
//   times in a row. A stuck memory is abandoned after TIMEOUT_CYC wait cycles,
//   and the access is then acked with an error.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   flush               redirect: kills the pending or in-flight fetch ack
//   if_req/if_addr      fetch request (held until if_ack)
//   if_rdata/if_ack/if_err   fetch response (one-cycle ack pulse)
//   dm_req/dm_we/dm_addr/dm_wdata   load/store request (held until dm_ack)
//   dm_rdata/dm_ack/dm_err          load/store response (one-cycle ack pulse)
//   mem_req/mem_we/mem_addr/mem_wdata   memory strobe, held until mem_ready
//   mem_rdata/mem_ready             memory response
//   stall_if, stall_mem             pipeline freeze requests
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no access in flight; arbitrate between dm_req and if_req
// ST_BUSY_DM | data access on the memory bus, waiting for mem_ready
// ST_BUSY_IF | fetch on the memory bus, waiting for mem_ready
module pipeline_mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SW     = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_DM = 2'd1,
        ST_BUSY_IF = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                if_err_q, if_err_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                dm_ack_q, dm_ack_d;
    logic                dm_err_q, dm_err_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                flush_seen_q, flush_seen_d;

    logic force_if;
    logic timed_out;
    logic if_drop;

    // Fetch has waited through STARVE_LIMIT data grants: it must go next.
    assign force_if  = if_req && (starve_q == SW'(STARVE_LIMIT));
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT_CYC));
    // A flush in the completing cycle counts as well as an earlier one.
    assign if_drop   = flush_seen_q | flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            dm_rdata_q   <= '0;
            dm_ack_q     <= 1'b0;
            dm_err_q     <= 1'b0;
            starve_q     <= '0;
            wait_q       <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_ack_q     <= dm_ack_d;
            dm_err_q     <= dm_err_d;
            starve_q     <= starve_d;
            wait_q       <= wait_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_ack_d     = 1'b0;
        dm_err_d     = 1'b0;
        starve_d     = starve_q;
        wait_d       = wait_q;
        flush_seen_d = flush_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (dm_req && !force_if) begin
                    state_d     = ST_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    wait_d      = '0;
                    if (if_req && (starve_q != SW'(STARVE_LIMIT))) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (if_req && !flush) begin
                    state_d      = ST_BUSY_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    wait_d       = '0;
                    starve_d     = '0;
                    flush_seen_d = 1'b0;
                end
            end

            ST_BUSY_DM: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    // A store leaves the last load result visible.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_err_d   = 1'b1;
                    dm_rdata_d = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_BUSY_IF: begin
                flush_seen_d = flush_seen_q | flush;
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!if_drop) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata[31:0];
                    end
                end else if (timed_out) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!if_drop) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_err    = dm_err_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Testbench for pipeline_mem_arbiter. The bench plays the memory and both
// requesters; expected responses go into per-port queues at issue time and a
// monitor pops them when the DUT acks.
module tb_pipeline_mem_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SLIM = 4;
    localparam int TCYC = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ack, if_err;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          dm_ack, dm_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;
    logic          stall_if, stall_mem;

    pipeline_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIM), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Unwritten memory returns a fixed function of the address.
    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0] + 32'h0000_1357};
    endfunction

    logic [63:0] mem_arr [logic [63:0]];
    logic [63:0] dm_ref  [logic [63:0]];
    logic [63:0] dm_last_rd = 64'h0;

    int mem_mode  = 0;   // 0 fixed latency, 1 random latency, 2 never ready
    int fixed_lat = 0;
    int wait_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Memory model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && mem_mode != 2) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : pat(mem_addr);
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                end else begin
                    wait_left--;
                    mem_ready = 1'b0;
                    mem_rdata = {$urandom, $urandom};
                end
            end else begin
                // In random mode, stray mem_ready pulses while idle must be ignored.
                mem_ready = (mem_mode == 1 && !mem_req) ? ($urandom_range(0, 3) == 0) : 1'b0;
                mem_rdata = {$urandom, $urandom};
                wait_left = (mem_mode == 1) ? int'($urandom_range(0, 3)) : fixed_lat;
            end
        end
    end

    // Monitor / scoreboard
    logic        prev_req = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
    logic [63:0] prev_addr = '0, prev_wdata = '0;
    int run_len = 0, last_len = 0;
    int if_ack_cnt = 0, dm_ack_cnt = 0;
    bit grant_log[$];

    initial begin
        exp_t e;
        bit   is_dm;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req   = 1'b0;
                prev_ready = 1'b0;
                run_len    = 0;
            end else begin
                check("stall_if", 64'(stall_if), 64'(if_req & ~if_ack));
                check("stall_mem", 64'(stall_mem), 64'(dm_req & ~dm_ack));
                if (if_ack || dm_ack) check("ack_exclusive", 64'(if_ack & dm_ack), 64'(0));
                if (if_ack) begin
                    if_ack_cnt++;
                    if (if_q.size() == 0) fail_now("if_ack_unexpected", "if_ack with nothing outstanding");
                    else begin
                        e = if_q.pop_front();
                        check("if_rdata", 64'(if_rdata), 64'(e.data[31:0]));
                        check("if_err", 64'(if_err), 64'(e.err));
                    end
                end
                if (dm_ack) begin
                    dm_ack_cnt++;
                    if (dm_q.size() == 0) fail_now("dm_ack_unexpected", "dm_ack with nothing outstanding");
                    else begin
                        e = dm_q.pop_front();
                        check("dm_rdata", dm_rdata, e.data);
                        check("dm_err", 64'(dm_err), 64'(e.err));
                    end
                end
                if (mem_req && !prev_req) begin
                    is_dm = (mem_addr >= 64'h100) && (mem_addr < 64'h200);
                    grant_log.push_back(is_dm);
                    if (!is_dm) begin
                        check("if_grant_we", 64'(mem_we), 64'(0));
                        check("if_grant_wdata", mem_wdata, 64'(0));
                    end
                end
                if (mem_req && prev_req && !prev_ready) begin
                    check("mem_addr_stable", mem_addr, prev_addr);
                    check("mem_wdata_stable", mem_wdata, prev_wdata);
                    check("mem_we_stable", 64'(mem_we), 64'(prev_we));
                end
                if (mem_req) run_len++;
                else if (prev_req) begin
                    last_len = run_len;
                    run_len  = 0;
                end
                prev_req   = mem_req;
                prev_ready = mem_ready;
                prev_we    = mem_we;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end
        end
    end

    task automatic do_if(input logic [63:0] a, output int ack_cyc);
        exp_t e;
        int   n;
        e.data = pat(a);
        e.err  = 1'b0;
        if_q.push_back(e);
        if_req  = 1'b1;
        if_addr = a;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!if_ack && n < 400);
        if (!if_ack) fail_now("if_ack_wait", "no if_ack within 400 cycles");
        ack_cyc = cyc;
        if_req  = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [63:0] a, input logic [63:0] d,
                         input bit expect_to, output int ack_cyc);
        exp_t e;
        int   n;
        e.err = 1'b0;
        if (expect_to) begin
            e.data     = '0;
            e.err      = 1'b1;
            dm_last_rd = '0;
        end else if (we) begin
            dm_ref[a] = d;
            e.data    = dm_last_rd;
        end else begin
            e.data     = dm_ref.exists(a) ? dm_ref[a] : pat(a);
            dm_last_rd = e.data;
        end
        dm_q.push_back(e);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dm_ack && n < 400);
        if (!dm_ack) fail_now("dm_ack_wait", "no dm_ack within 400 cycles");
        ack_cyc = cyc;
        dm_req  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c_if, c_dm, n, cnt0;
        logic [4:0] gv;
        exp_t e;

        reset = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", mem_addr, 64'(0));
        check("rst_mem_wdata", mem_wdata, 64'(0));
        check("rst_if_rdata", 64'(if_rdata), 64'(0));
        check("rst_if_ack", 64'(if_ack), 64'(0));
        check("rst_if_err", 64'(if_err), 64'(0));
        check("rst_dm_rdata", dm_rdata, 64'(0));
        check("rst_dm_ack", 64'(dm_ack), 64'(0));
        check("rst_dm_err", 64'(dm_err), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch with zero-wait memory: ack two cycles after the request.
        mem_mode = 0; fixed_lat = 0;
        t0 = cyc;
        do_if(64'h0, c_if);
        check("fetch_latency", 64'(c_if - t0), 64'(2));

        // Simultaneous requests: the store goes first.
        fork
            do_dm(1'b1, 64'h100, 64'h0000_0000_DEAD_BEEF, 1'b0, c_dm);
            do_if(64'h1000, c_if);
        join
        check("dm_before_if", 64'(c_dm < c_if), 64'(1));
        do_dm(1'b0, 64'h100, 64'h0, 1'b0, c_dm);

        // Starvation: DM held continuously, fetch must get the 5th grant.
        do_if(64'h1004, c_if);
        grant_log.delete();
        e.data = dm_ref.exists(64'h108) ? dm_ref[64'h108] : pat(64'h108);
        e.err  = 1'b0;
        dm_last_rd = e.data;
        repeat (5) dm_q.push_back(e);
        e.data = pat(64'h1008);
        if_q.push_back(e);
        fork
            begin
                int k, m;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h108; dm_wdata = '0;
                k = 0; m = 0;
                while (k < 5 && m < 300) begin
                    @(posedge clk);
                    #1;
                    m++;
                    if (dm_ack) k++;
                end
                dm_req = 1'b0;
                if (k < 5) fail_now("starve_dm_wait", "DM acks missing");
            end
            begin
                int m;
                if_req = 1'b1; if_addr = 64'h1008;
                m = 0;
                do begin
                    @(posedge clk);
                    #1;
                    m++;
                end while (!if_ack && m < 300);
                if_req = 1'b0;
                if (!if_ack) fail_now("starve_if_wait", "fetch never acked");
            end
        join
        gv = '0;
        for (int i = 0; i < 5; i++) if (i < grant_log.size()) gv[4-i] = grant_log[i];
        check("starve_grant_order", 64'(gv), 64'(5'b11110));

        // Timeout: memory never answers.
        mem_mode = 2;
        do_dm(1'b0, 64'h110, 64'h0, 1'b1, c_dm);
        @(posedge clk);
        #1;
        check("timeout_req_cycles", 64'(last_len), 64'(TCYC + 1));
        mem_mode = 0;

        // Flush during a fetch: memory completes, no if_ack.
        fixed_lat = 3;
        @(posedge clk);
        #1;
        cnt0 = if_ack_cnt;
        if_req = 1'b1; if_addr = 64'h20;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_req && n < 20);
        if (!mem_req) fail_now("flush_grant_wait", "fetch never granted");
        flush = 1'b1; if_req = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("flush_no_if_ack", 64'(if_ack_cnt), 64'(cnt0));
        check("flush_mem_side_len", 64'(last_len), 64'(4));
        fixed_lat = 0;
        @(posedge clk);
        #1;
        do_if(64'h40, c_if);
        flush = 1'b1;
        fork
            do_if(64'h44, c_if);
            begin
                @(posedge clk);
                #1;
                check("flush_blocks_grant", 64'(mem_req), 64'(0));
                flush = 1'b0;
            end
        join

        // Reset in the middle of a data access.
        mem_mode = 2;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h118;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_req && n < 20);
        if (!mem_req) fail_now("rst_grant_wait", "DM never granted");
        repeat (2) @(posedge clk);
        #1;
        cnt0 = dm_ack_cnt;
        reset = 1'b0;
        #1;
        check("rst_async_mem_req", 64'(mem_req), 64'(0));
        check("rst_async_dm_ack", 64'(dm_ack), 64'(0));
        dm_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_mode = 0;
        dm_last_rd = '0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_dm_ack", 64'(dm_ack_cnt), 64'(cnt0));
        check("rst_idle_mem_req", 64'(mem_req), 64'(0));
        do_dm(1'b0, 64'h118, 64'h0, 1'b0, c_dm);

        // Random traffic from both ports.
        mem_mode = 1;
        fork
            begin
                int cc;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #0;
                    @(posedge clk);
                    #1;
                    do_if(64'h1000 + 64'(4 * $urandom_range(0, 1023)), cc);
                end
            end
            begin
                int cc;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk);
                    #1;
                    do_dm(1'($urandom_range(0, 1)), 64'h100 + 64'(8 * $urandom_range(0, 15)),
                          {$urandom, $urandom}, 1'b0, cc);
                end
            end
        join

        mem_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("if_q_drained", 64'(if_q.size()), 64'(0));
        check("dm_q_drained", 64'(dm_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
